// File: rtl/addrnu_seq_chk.sv
// addrnu_seq_chk: digit-serial adder with mod-3 residue check, fault injection and bounded retry
module addrnu_seq_chk #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  parameter int MAX_RETRY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inj,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err,
  output logic             retried
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [2:0] MR = 3'(MAX_RETRY);
  localparam logic [WIDTH:0] THREE = (WIDTH+1)'(3);
  if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0 || MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_bad_params
    $error("addrnu_seq_chk: illegal WIDTH/DIGIT/MAX_RETRY combination");
  end
  typedef enum logic [1:0] {IDLE, ADD, CHECK, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic inj_r, carry, last, mod_ok;
  logic [CW-1:0] cnt;
  logic [2:0] rcnt;
  logic [DIGIT:0] dsum;
  logic [WIDTH:0] ra, rb, rs;
  always_comb begin
    dsum = {1'b0, a_r[cnt*DIGIT +: DIGIT]} + {1'b0, b_r[cnt*DIGIT +: DIGIT]} + {{DIGIT{1'b0}}, carry};
    last = cnt == CW'(N-1);
    ra = {1'b0, a_r} % THREE;
    rb = {1'b0, b_r} % THREE;
    rs = sum % THREE;
    mod_ok = ((ra + rb) % THREE) == rs;
  end
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      inj_r <= 1'b0;
      carry <= 1'b0;
      cnt <= '0;
      rcnt <= '0;
      sum <= '0;
      err <= 1'b0;
      retried <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= b;
          inj_r <= inj;
          cnt <= '0;
          carry <= 1'b0;
          rcnt <= '0;
          err <= 1'b0;
          retried <= 1'b0;
          state <= ADD;
        end
        ADD: begin
          // injected fault flips only the visible LSB; the carry chain stays true
          sum[cnt*DIGIT +: DIGIT] <= dsum[DIGIT-1:0] ^ DIGIT'(inj_r && cnt == '0);
          carry <= dsum[DIGIT];
          cnt <= cnt + 1'b1;
          if (last) begin
            sum[WIDTH] <= dsum[DIGIT];
            state <= CHECK;
          end
        end
        CHECK: begin
          if (mod_ok) begin
            err <= 1'b0;
            state <= DONE;
          end else if (rcnt < MR) begin
            rcnt <= rcnt + 1'b1;
            retried <= 1'b1;
            cnt <= '0;
            carry <= 1'b0;
            inj_r <= 1'b0;
            state <= ADD;
          end else begin
            err <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
